// File: rtl/rr_decode_grant_arbiter.sv
// Round-robin arbiter sharing one one-hot select resource among 2**IDX_W requesters.
// Holds each grant until release, request drop, or a MAX_HOLD timeout; always idles one cycle between grants.
module rr_decode_grant_arbiter #(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [(1 << IDX_W)-1:0]   i_req,
    input  logic                      i_release,
    output logic [(1 << IDX_W)-1:0]   o_grant_out,
    output logic [IDX_W-1:0]          o_grant_idx,
    output logic                      o_grant_valid,
    output logic                      o_timeout_pulse
);

    localparam int unsigned N_REQ = 1 << IDX_W;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [N_REQ-1:0]    r_grant_out;
    logic [IDX_W-1:0]    r_grant_idx;
    logic                r_grant_valid;
    logic                r_timeout;

    logic [IDX_W-1:0]    w_scan;
    logic [IDX_W-1:0]    w_winner;
    logic                w_found;
    logic [N_REQ-1:0]    w_decode;

    // First set request at or after r_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_scan   = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_scan = r_ptr + IDX_W'(k);
            if (!w_found && i_req[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    assign w_decode = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant_out   <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_enable && w_found) begin
                        r_grant_idx   <= w_winner;
                        r_grant_out   <= w_decode;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= HOLD_W'(1);
                        r_state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Release/drop outranks the timeout, so a release on the last hold cycle is a normal exit.
                    if (i_release || !i_req[r_grant_idx] || (r_hold_cnt == HOLD_W'(MAX_HOLD))) begin
                        r_timeout     <= !(i_release || !i_req[r_grant_idx]);
                        r_ptr         <= r_grant_idx + IDX_W'(1);
                        r_grant_idx   <= '0;
                        r_grant_out   <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant_out     = r_grant_out;
    assign o_grant_idx     = r_grant_idx;
    assign o_grant_valid   = r_grant_valid;
    assign o_timeout_pulse = r_timeout;

endmodule
